// File: rtl/simd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simd_pkg
// Description : Shared types and default lane geometry for the SIMD result path.
// Revision    : 1.0 - initial release
// ============================================================================
package simd_pkg;

    localparam int SIMD_PE_COUNT   = 4;
    localparam int SIMD_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/drain_fifo.sv
`default_nettype none
// ============================================================================
// Module      : drain_fifo
// Description : Synchronous word FIFO; the head word is visible without a pop.
// Revision    : 1.0 - initial release
// ============================================================================
module drain_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push && (r_count != c_cnt_w'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
// Module      : result_drain
// Description : Reads result BRAM words and serialises their lanes onto an
//               AXI-stream. Define RESULT_DRAIN_PERF_EN for the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module result_drain
    import simd_pkg::*;
#(
    parameter int PE_COUNT     = SIMD_PE_COUNT,
    parameter int DATA_WIDTH   = SIMD_DATA_WIDTH,
    parameter int BRAM_DEPTH   = 1024,
    parameter int ADDR_WIDTH   = $clog2(BRAM_DEPTH),
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            word_count,
    output logic                           busy,
    output logic                           done,
    output logic                           bram_en,
    output logic [ADDR_WIDTH-1:0]          bram_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           m_tlast
`ifdef RESULT_DRAIN_PERF_EN
    ,
    output logic [31:0]                    stall_cycles
`endif
);

    localparam int c_lane_w = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
    localparam int c_word_w = PE_COUNT * DATA_WIDTH;
    localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);
    localparam int c_cred_w = c_cnt_w + 1;
    localparam int c_wc_w   = ADDR_WIDTH + 1;
    localparam logic [c_wc_w-1:0]     c_max_words = c_wc_w'(BRAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(BRAM_DEPTH - 1);
    localparam logic [c_lane_w-1:0]   c_last_lane = c_lane_w'(PE_COUNT - 1);

    drain_state_t          r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_bram_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_wc_w-1:0]     r_reads_left;
    logic [c_wc_w-1:0]     r_words_left;
    logic [c_cred_w-1:0]   r_inflight;
    logic [READ_LATENCY-1:0] r_rd_pipe;
    logic [c_lane_w-1:0]   r_lane;

    logic [c_word_w-1:0]   w_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_cnt_w-1:0]    w_fifo_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;
    logic                  w_last;
    logic                  w_hs;
    logic                  w_credit_ok;
    logic                  w_start_go;
    logic                  w_issue;
    logic [c_wc_w-1:0]     w_word_cnt;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [DATA_WIDTH-1:0] w_lane_data;

    // A read retires into the FIFO exactly READ_LATENCY cycles after it was issued.
    assign w_push      = r_rd_pipe[READ_LATENCY-1];
    assign w_valid     = !w_fifo_empty;
    assign w_last      = w_valid && (r_lane == c_last_lane) && (r_words_left == c_wc_w'(1));
    assign w_hs        = w_valid && m_tready;
    assign w_pop       = w_hs && (r_lane == c_last_lane);
    assign w_credit_ok = !w_fifo_full &&
                         ((r_inflight + c_cred_w'(w_fifo_count)) < c_cred_w'(FIFO_DEPTH));
    assign w_word_cnt  = (word_count > c_max_words) ? c_max_words : word_count;
    assign w_start_go  = (r_state == IDLE) && start && (w_word_cnt != '0);
    assign w_issue     = (r_state == READ) && (r_reads_left != '0) && w_credit_ok;
    assign w_next_addr = (r_addr == c_last_addr) ? '0 : r_addr + ADDR_WIDTH'(1);

    drain_fifo #(
        .WIDTH (c_word_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (bram_dout),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    always_comb begin
        w_lane_data = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            if (w_valid && (r_lane == c_lane_w'(i))) begin
                w_lane_data = w_head[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bram_en    <= 1'b0;
            r_addr       <= '0;
            r_reads_left <= '0;
            r_words_left <= '0;
            r_inflight   <= '0;
            r_rd_pipe    <= '0;
            r_lane       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_bram_en  <= w_start_go || w_issue;
            r_rd_pipe  <= (r_rd_pipe << 1) | READ_LATENCY'(r_bram_en);
            r_inflight <= r_inflight + c_cred_w'(w_start_go || w_issue) - c_cred_w'(w_push);

            if (w_start_go) begin
                r_addr       <= base_addr;
                r_reads_left <= w_word_cnt - c_wc_w'(1);
                r_words_left <= w_word_cnt;
                r_lane       <= '0;
            end else begin
                if (w_issue) begin
                    r_addr       <= w_next_addr;
                    r_reads_left <= r_reads_left - c_wc_w'(1);
                end
                if (w_hs) begin
                    r_lane <= (r_lane == c_last_lane) ? '0 : r_lane + c_lane_w'(1);
                end
                if (w_pop) begin
                    r_words_left <= r_words_left - c_wc_w'(1);
                end
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_word_cnt != '0) begin
                            r_state <= READ;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (w_hs && w_last) begin
                        r_state <= FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_reads_left == '0) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_hs && w_last) begin
                        r_state <= FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                FINISH: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef RESULT_DRAIN_PERF_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst || ((r_state == IDLE) && start)) begin
            r_stall <= '0;
        end else if (w_valid && !m_tready && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign bram_en   = r_bram_en;
    assign bram_addr = r_addr;
    assign m_tdata   = w_lane_data;
    assign m_tvalid  = w_valid;
    assign m_tlast   = w_last;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_drain
// Description : Self-checking bench for result_drain against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_drain;

    localparam int PE    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int RL    = 1;
    localparam int FD    = 4;
    localparam int WW    = PE * DW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [WW-1:0] bram_dout;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
`ifdef RESULT_DRAIN_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    result_drain #(
        .PE_COUNT(PE), .DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .READ_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .bram_en(bram_en),
        .bram_addr(bram_addr), .bram_dout(bram_dout), .m_tdata(m_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
`ifdef RESULT_DRAIN_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    logic [WW-1:0] mem [DEPTH];
    int cyc;
    int checks;
    int errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr];
    end

    // Observations collected per transfer.
    int            addr_q[$];
    logic [DW-1:0] beat_q[$];
    bit            last_q[$];
    int            bcyc_q[$];
    int issued, first_en, first_valid, done_cnt, done_cyc;
    int stab_err, credit_err, done_busy_err, stall_m;
    bit busy_seen, prev_hold, prev_last;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (bram_en) begin
                addr_q.push_back(int'(bram_addr));
                issued++;
                if (first_en < 0) first_en = cyc;
            end
            if (issued - (beat_q.size() / PE) > FD) credit_err++;
            if (m_tvalid && first_valid < 0) first_valid = cyc;
            if (prev_hold && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last))
                stab_err++;
            if (m_tvalid && m_tready) begin
                beat_q.push_back(m_tdata);
                last_q.push_back(m_tlast);
                bcyc_q.push_back(cyc);
            end
            if (m_tvalid && !m_tready) stall_m++;
            prev_hold = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_last = m_tlast;
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) done_busy_err++;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        addr_q.delete(); beat_q.delete(); last_q.delete(); bcyc_q.delete();
        issued = 0; first_en = -1; first_valid = -1; done_cnt = 0; done_cyc = -1;
        stab_err = 0; credit_err = 0; done_busy_err = 0; stall_m = 0;
        busy_seen = 1'b0; prev_hold = 1'b0;
    endtask

    function automatic logic tready_for(input int mode, input int k);
        if (mode == 1) return (k % 2) == 0;
        if (mode == 2) return $urandom_range(0, 3) != 0;
        return 1'b1;
    endfunction

    function automatic logic [DW-1:0] model_beat(input int base, input int i);
        logic [WW-1:0] w;
        w = mem[(base + i / PE) % DEPTH];
        return w[(i % PE) * DW +: DW];
    endfunction

    task automatic run_xfer(input int base, input int cnt, input int mode,
                            input int intrude, input string tag);
        int words, nb, ts, budget, k, bad;
        bit to;
        words = (cnt > DEPTH) ? DEPTH : cnt;
        nb = words * PE;
        to = 1'b0;
        @(posedge clk); #1;
        clear_obs();
        start = 1'b1; base_addr = AW'(base); word_count = (AW+1)'(cnt);
        ts = cyc + 1;
        m_tready = tready_for(mode, 0);
        budget = nb * 4 + 40;
        k = 0;
        forever begin
            @(posedge clk); #1;
            k++;
            if (done_cnt > 0) break;
            if (k > budget) begin to = 1'b1; break; end
            start = (k == intrude);
            if (k == intrude) begin base_addr = AW'(500); word_count = (AW+1)'(1); end
            m_tready = tready_for(mode, k);
        end
        start = 1'b0;
        check({tag, "_timeout"}, to, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_beats"}, beat_q.size(), nb);
        bad = 0;
        for (int i = 0; i < beat_q.size() && i < nb; i++)
            if (beat_q[i] !== model_beat(base, i)) bad++;
        check({tag, "_data_errs"}, bad, 0);
        bad = 0;
        for (int i = 0; i < last_q.size(); i++)
            if (last_q[i] != (i == nb - 1)) bad++;
        check({tag, "_tlast_errs"}, bad, 0);
        check({tag, "_reads"}, addr_q.size(), words);
        bad = 0;
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] != (base + i) % DEPTH) bad++;
        check({tag, "_addr_errs"}, bad, 0);
        check({tag, "_unstable"}, stab_err, 0);
        check({tag, "_credit"}, credit_err, 0);
        check({tag, "_busy_at_done"}, done_busy_err, 0);
        check({tag, "_busy_seen"}, busy_seen, words != 0);
        if (words == 0) begin
            check({tag, "_done_cyc"}, done_cyc, ts);
            check({tag, "_no_en"}, first_en, -1);
            check({tag, "_no_valid"}, first_valid, -1);
        end else begin
            check({tag, "_first_en"}, first_en, ts);
            check({tag, "_first_valid"}, first_valid, ts + 1 + RL);
            if (bcyc_q.size() > 0)
                check({tag, "_done_after_last"}, done_cyc, bcyc_q[bcyc_q.size()-1] + 1);
            if (mode == 0 && bcyc_q.size() > 0)
                check({tag, "_no_bubbles"}, bcyc_q[bcyc_q.size()-1] - bcyc_q[0], nb - 1);
        end
`ifdef RESULT_DRAIN_PERF_EN
        check({tag, "_stall_cycles"}, stall_cycles, stall_m);
`endif
    endtask

    typedef struct {
        int base;
        int cnt;
        int mode;
        int intrude;
        int exp_beats;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int k;
        cyc = 0; checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        m_tready = 1'b0; bram_dout = '0;
        clear_obs();
        for (int a = 0; a < DEPTH; a++)
            for (int l = 0; l < PE; l++)
                mem[a][l*DW +: DW] = DW'(a * PE + l);

        vecs[0] = '{base: 0,    cnt: 2,    mode: 0, intrude: 0, exp_beats: 8};
        vecs[1] = '{base: 5,    cnt: 3,    mode: 1, intrude: 0, exp_beats: 12};
        vecs[2] = '{base: 1022, cnt: 4,    mode: 0, intrude: 0, exp_beats: 16};
        vecs[3] = '{base: 7,    cnt: 0,    mode: 0, intrude: 0, exp_beats: 0};
        vecs[4] = '{base: 10,   cnt: 3,    mode: 1, intrude: 4, exp_beats: 12};
        vecs[5] = '{base: 1000, cnt: 2000, mode: 0, intrude: 0, exp_beats: 4096};
        vecs[6] = '{base: 1023, cnt: 1,    mode: 2, intrude: 0, exp_beats: 4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
`ifdef RESULT_DRAIN_PERF_EN
        check("rst_stall", stall_cycles, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_xfer(vecs[v].base, vecs[v].cnt, vecs[v].mode, vecs[v].intrude,
                     $sformatf("vec%0d", v));
            check($sformatf("vec%0d_table_beats", v), beat_q.size(), vecs[v].exp_beats);
        end

        // Reset in the middle of a transfer, after three accepted beats.
        @(posedge clk); #1;
        clear_obs();
        start = 1'b1; base_addr = '0; word_count = (AW+1)'(4); m_tready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (beat_q.size() < 3 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("midrst_reached_3_beats", beat_q.size(), 3);
        rst = 1'b1; m_tready = 1'b0;
        @(posedge clk); #1;
        check("midrst_tvalid", m_tvalid, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0; m_tready = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_more_beats", beat_q.size(), 3);
        check("midrst_no_valid_after", m_tvalid, 0);
        run_xfer(0, 4, 0, 0, "post_rst");

        // Randomised transfers against the memory model.
        for (int a = 0; a < DEPTH; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
        for (int r = 0; r < 24; r++) begin
            int cnt;
            cnt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            run_xfer(int'($urandom_range(0, DEPTH - 1)), cnt, 2,
                     ($urandom_range(0, 1) == 1) ? 3 : 0, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
